// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: memory word, RAM handshake state and the
// arbiter FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a waiting fetch is forced through after STARVE_MAX data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [2:0] r_starve;
    logic [2:0] w_starve_next;
    logic       w_dreq;

    assign w_dreq = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= 3'd0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve;
        iwait         = iREN;
        dwait         = w_dreq;
        iload         = '0;
        dload         = '0;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ramaddr       = '0;
        ramstore      = '0;

        // Starvation only accumulates while a fetch is actually waiting.
        if (!iREN) begin
            w_starve_next = 3'd0;
        end

        case (r_state)
            IDLE: begin
                if (w_dreq && ((r_starve < STARVE_LIM) || !iREN)) begin
                    w_state_next = DGRANT;
                end else if (iREN) begin
                    w_state_next = IGRANT;
                end
            end

            DGRANT: begin
                if (!w_dreq) begin
                    w_state_next = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == ACCESS) begin
                        dwait        = 1'b0;
                        dload        = ramload;
                        w_state_next = IDLE;
                        if (iREN && (r_starve < STARVE_LIM)) begin
                            w_starve_next = r_starve + 3'd1;
                        end
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    w_state_next = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait         = 1'b0;
                        iload         = ramload;
                        w_state_next  = IDLE;
                        w_starve_next = 3'd0;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// reset sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam word_t AI = 32'h0000_0040;
    localparam word_t AD = 32'h0000_0100;
    localparam word_t ST = 32'hDEAD_BEEF;
    localparam word_t LD = 32'h8C01_0004;
    localparam word_t Z  = 32'h0;
    localparam int    NV = 39;

    typedef struct packed {
        logic      ir, dr, dw;
        ramstate_t rs;
        logic      eiw, edw, eren, ewen;
        word_t     eaddr, est, eil, edl;
    } vec_t;

    logic      CLK, nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;
    vec_t tbl [NV];

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic ir, dr, dw, input ramstate_t rs,
                                input logic eiw, edw, eren, ewen,
                                input word_t eaddr, est, eil, edl);
        vec_t v;
        v = '{ir, dr, dw, rs, eiw, edw, eren, ewen, eaddr, est, eil, edl};
        return v;
    endfunction

    task automatic drive(input logic ir, dr, dw, input ramstate_t rs);
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    endtask

    task automatic check(input string name, input logic eiw, edw, eren, ewen,
                         input word_t eaddr, est, eil, edl);
        logic [131:0] act, exp;
        act = {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
        exp = {eiw, edw, eren, ewen, eaddr, est, eil, edl};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h, want iw=%b dw=%b ren=%b wen=%b addr=%h st=%h il=%h dl=%h",
                     name, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload,
                     eiw, edw, eren, ewen, eaddr, est, eil, edl);
        end else begin
            $display("ok   %s: iw=%b dw=%b ren=%b wen=%b addr=%h il=%h dl=%h",
                     name, iwait, dwait, ramREN, ramWEN, ramaddr, iload, dload);
        end
    endtask

    initial begin
        // fetch alone, completes on the second cycle
        tbl[0]  = mk(0,0,0,FREE,   0,0,0,0, Z, Z, Z, Z);
        tbl[1]  = mk(1,0,0,FREE,   1,0,0,0, Z, Z, Z, Z);
        tbl[2]  = mk(1,0,0,ACCESS, 0,0,1,0, AI,Z, LD,Z);
        tbl[3]  = mk(0,0,0,FREE,   0,0,0,0, Z, Z, Z, Z);
        // simultaneous fetch + load: data first, then fetch
        tbl[4]  = mk(1,1,0,FREE,   1,1,0,0, Z, Z, Z, Z);
        tbl[5]  = mk(1,1,0,BUSY,   1,1,1,0, AD,ST,Z, Z);
        tbl[6]  = mk(1,1,0,ACCESS, 1,0,1,0, AD,ST,Z, LD);
        tbl[7]  = mk(1,0,0,FREE,   1,0,0,0, Z, Z, Z, Z);
        tbl[8]  = mk(1,0,0,ACCESS, 0,0,1,0, AI,Z, LD,Z);
        tbl[9]  = mk(0,0,0,FREE,   0,0,0,0, Z, Z, Z, Z);
        // store with three BUSY cycles
        tbl[10] = mk(0,0,1,FREE,   0,1,0,0, Z, Z, Z, Z);
        tbl[11] = mk(0,0,1,BUSY,   0,1,0,1, AD,ST,Z, Z);
        tbl[12] = mk(0,0,1,BUSY,   0,1,0,1, AD,ST,Z, Z);
        tbl[13] = mk(0,0,1,BUSY,   0,1,0,1, AD,ST,Z, Z);
        tbl[14] = mk(0,0,1,ACCESS, 0,0,0,1, AD,ST,Z, LD);
        // dREN+dWEN treated as store, ERROR retried
        tbl[15] = mk(0,1,1,FREE,   0,1,0,0, Z, Z, Z, Z);
        tbl[16] = mk(0,1,1,ERROR,  0,1,0,1, AD,ST,Z, Z);
        tbl[17] = mk(0,1,1,ACCESS, 0,0,0,1, AD,ST,Z, LD);
        tbl[18] = mk(0,0,0,FREE,   0,0,0,0, Z, Z, Z, Z);
        // load dropped mid-grant; stray ACCESS afterwards is ignored
        tbl[19] = mk(0,1,0,FREE,   0,1,0,0, Z, Z, Z, Z);
        tbl[20] = mk(0,1,0,BUSY,   0,1,1,0, AD,ST,Z, Z);
        tbl[21] = mk(0,0,0,BUSY,   0,0,0,0, Z, Z, Z, Z);
        tbl[22] = mk(0,0,0,ACCESS, 0,0,0,0, Z, Z, Z, Z);
        // fetch dropped mid-grant
        tbl[23] = mk(1,0,0,FREE,   1,0,0,0, Z, Z, Z, Z);
        tbl[24] = mk(0,0,0,BUSY,   0,0,0,0, Z, Z, Z, Z);
        tbl[25] = mk(0,0,0,ACCESS, 0,0,0,0, Z, Z, Z, Z);
        // starvation: four stores, forced fetch, then data again
        for (int k = 0; k < 4; k++) begin
            tbl[26 + 2*k] = mk(1,0,1,FREE,   1,1,0,0, Z, Z, Z, Z);
            tbl[27 + 2*k] = mk(1,0,1,ACCESS, 1,0,0,1, AD,ST,Z, LD);
        end
        tbl[34] = mk(1,0,1,FREE,   1,1,0,0, Z, Z, Z, Z);
        tbl[35] = mk(1,0,1,ACCESS, 0,1,1,0, AI,Z, LD,Z);
        tbl[36] = mk(1,0,1,FREE,   1,1,0,0, Z, Z, Z, Z);
        tbl[37] = mk(1,0,1,ACCESS, 1,0,0,1, AD,ST,Z, LD);
        tbl[38] = mk(0,0,0,FREE,   0,0,0,0, Z, Z, Z, Z);

        iaddr = AI; daddr = AD; dstore = ST; ramload = LD;
        drive(1, 0, 0, BUSY);
        nRST = 1'b0;

        // reset state, with a fetch already requested
        @(negedge CLK);
        #1 check("reset_hold", 1,0,0,0, Z, Z, Z, Z);
        drive(0, 0, 0, FREE);
        #1 check("reset_idle", 0,0,0,0, Z, Z, Z, Z);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rs);
            #1 check($sformatf("vec%0d", i), tbl[i].eiw, tbl[i].edw, tbl[i].eren,
                     tbl[i].ewen, tbl[i].eaddr, tbl[i].est, tbl[i].eil, tbl[i].edl);
        end

        // saturate the starvation counter, enter IGRANT, reset while BUSY
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); drive(1, 0, 1, FREE);
            @(negedge CLK); drive(1, 0, 1, ACCESS);
        end
        @(negedge CLK); drive(1, 0, 1, FREE);
        @(negedge CLK); drive(1, 0, 1, BUSY);
        #1 check("starved_igrant_busy", 1,1,1,0, AI, Z, Z, Z);
        #1 nRST = 1'b0;
        #1 check("async_reset_mid_grant", 1,1,0,0, Z, Z, Z, Z);
        @(negedge CLK);
        #1 check("reset_held_over_edge", 1,1,0,0, Z, Z, Z, Z);
        nRST = 1'b1;
        drive(1, 0, 1, FREE);
        #1 check("post_reset_idle", 1,1,0,0, Z, Z, Z, Z);
        // a cleared counter lets data win over the pending fetch
        @(negedge CLK); drive(1, 0, 1, ACCESS);
        #1 check("post_reset_dgrant", 1,0,0,1, AD, ST, Z, LD);
        @(negedge CLK); drive(0, 0, 0, FREE);
        #1 check("final_idle", 0,0,0,0, Z, Z, Z, Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
